// File: rtl/aer_spike_encoder.sv
// Serialises per-cycle neuron spike pulses into timestamped AER words.
// A pending bitmap feeds a priority encoder into a show-ahead event FIFO.
module aer_spike_encoder #(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int TS_WIDTH    = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_NEURONS-1:0]        spike_in,
  input  logic                          aer_ready,
  output logic                          aer_valid,
  output logic [ADDR_WIDTH-1:0]         aer_addr,
  output logic [TS_WIDTH-1:0]           aer_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [DROP_WIDTH-1:0]         drop_count,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(NUM_NEURONS + 1);
  localparam int SW = ((DROP_WIDTH > LW) ? DROP_WIDTH : LW) + 1;
  localparam logic [SW-1:0] DROP_MAX = SW'({DROP_WIDTH{1'b1}});

  logic [TS_WIDTH-1:0]    ts_reg;
  logic [NUM_NEURONS-1:0] pending_reg;
  logic [PW-1:0]          wr_ptr_reg;
  logic [PW-1:0]          rd_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic [DROP_WIDTH-1:0]  drop_reg;

  logic [ADDR_WIDTH-1:0]  addr_mem [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]    ts_mem   [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [NUM_NEURONS-1:0] clear;
  logic [NUM_NEURONS-1:0] lost;
  logic [LW-1:0]          lost_cnt;
  logic [SW-1:0]          drop_sum;
  logic                   push;
  logic                   pop;
  logic                   can_push;

  // Lowest-index pending neuron wins; scanning downward leaves the lowest set bit.
  always_comb begin
    sel_addr = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending_reg[i]) sel_addr = ADDR_WIDTH'(i);
    end
  end

  assign pop      = (count_reg != '0) && aer_ready;
  assign can_push = (count_reg < CW'(FIFO_DEPTH)) || pop;
  assign push     = (|pending_reg) && can_push;
  assign clear    = push ? (NUM_NEURONS'(1) << sel_addr) : '0;

  // A spike onto a bit that is still pending (and not leaving this cycle) is lost.
  assign lost = spike_in & pending_reg & ~clear;

  always_comb begin
    lost_cnt = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      lost_cnt = lost_cnt + LW'(lost[i]);
    end
  end

  assign drop_sum = SW'(drop_reg) + SW'(lost_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_reg      <= '0;
      pending_reg <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      drop_reg    <= '0;
    end else begin
      ts_reg      <= ts_reg + TS_WIDTH'(1);
      pending_reg <= (pending_reg & ~clear) | spike_in;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      drop_reg <= (drop_sum > DROP_MAX) ? '1 : drop_sum[DROP_WIDTH-1:0];
    end
  end

  // Storage carries no reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= sel_addr;
      ts_mem[wr_ptr_reg]   <= ts_reg;
    end
  end

  assign aer_valid  = (count_reg != '0);
  assign aer_addr   = aer_valid ? addr_mem[rd_ptr_reg] : '0;
  assign aer_ts     = aer_valid ? ts_mem[rd_ptr_reg] : '0;
  assign fifo_count = count_reg;
  assign drop_count = drop_reg;
  assign busy       = (|pending_reg) || (count_reg != '0);

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Scoreboard bench for aer_spike_encoder: expected events are queued when spikes
// are driven and compared as the DUT hands them over on the AER stream.
module tb_aer_spike_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] spike_in = '0;
  logic        aer_ready = 1'b0;
  logic        aer_valid;
  logic [3:0]  aer_addr;
  logic [7:0]  aer_ts;
  logic [3:0]  fifo_count;
  logic [7:0]  drop_count;
  logic        busy;

  aer_spike_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .aer_ready  (aer_ready),
    .aer_valid  (aer_valid),
    .aer_addr   (aer_addr),
    .aer_ts     (aer_ts),
    .fifo_count (fifo_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference free-running timestamp, reset alongside the DUT.
  logic [7:0] ts_model;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_model <= '0;
    else        ts_model <= ts_model + 8'd1;
  end

  typedef struct {
    logic [3:0] addr;
    logic [7:0] ts;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int a, input int t);
    exp_q.push_back('{addr: 4'(a), ts: 8'(t)});
  endtask

  // Handshake completes on the next rising edge; inputs change only at posedge+1.
  always @(negedge clk) begin
    if (rst_n && aer_valid && aer_ready) begin
      check("event_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        $display("event addr=%0d ts=%0d exp_addr=%0d exp_ts=%0d",
                 aer_addr, aer_ts, mon_e.addr, mon_e.ts);
        check("aer_addr", aer_addr, mon_e.addr);
        check("aer_ts", aer_ts, mon_e.ts);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    spike_in = '0;
    aer_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_pending_events", exp_q.size(), 0);
    #1;
  endtask

  task automatic pulse(input logic [15:0] v);
    spike_in = v;
    tick();
    spike_in = '0;
    tick();
  endtask

  function automatic int sat_drop(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int r;

    // Reset values and minimum latency
    rst_n = 1'b0;
    #1;
    check("rst_valid", aer_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    do_reset();
    aer_ready = 1'b1;
    t = ts_model;
    spike_in = 16'h0004;
    push_exp(2, t + 1);
    tick();
    spike_in = '0;
    check("lat_e0_valid", aer_valid, 0);
    tick();
    check("lat_e1_valid", aer_valid, 1);
    check("lat_e1_addr", aer_addr, 2);
    check("lat_e1_busy", busy, 1);
    drain(10);

    // Reset mid-burst discards everything
    aer_ready = 1'b0;
    pulse(16'hFFFF);
    tick();
    check("burst_count_nonzero", 32'(fifo_count != 0), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", aer_valid, 0);
    check("midrst_addr", aer_addr, 0);
    check("midrst_ts", aer_ts, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_drop", drop_count, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    aer_ready = 1'b1;
    repeat (20) tick();
    check("post_rst_busy", busy, 0);

    // Simultaneous spikes leave in ascending address order
    do_reset();
    aer_ready = 1'b1;
    t = ts_model;
    spike_in = 16'h8421;
    push_exp(0, t + 1);
    push_exp(5, t + 2);
    push_exp(10, t + 3);
    push_exp(15, t + 4);
    tick();
    spike_in = '0;
    check("simul_busy", busy, 1);
    drain(20);
    check("simul_busy_done", busy, 0);
    check("simul_count_done", fifo_count, 0);

    // Back-pressure: FIFO fills, rest waits in pending
    do_reset();
    aer_ready = 1'b0;
    t = ts_model;
    spike_in = 16'hFFFF;
    for (int a = 0; a < 8; a++) push_exp(a, t + 1 + a);
    tick();
    spike_in = '0;
    repeat (12) tick();
    check("bp_count_full", fifo_count, 8);
    check("bp_drop", drop_count, 0);
    check("bp_busy", busy, 1);
    check("bp_valid", aer_valid, 1);
    check("bp_hold_addr", aer_addr, 0);
    check("bp_hold_ts", aer_ts, 8'(t + 1));
    r = ts_model;
    aer_ready = 1'b1;
    for (int a = 8; a < 16; a++) push_exp(a, r + a - 8);
    drain(40);
    check("bp_count_done", fifo_count, 0);

    // Same-bit re-spike in the encode cycle is a new event
    do_reset();
    aer_ready = 1'b1;
    t = ts_model;
    spike_in = 16'h0002;
    push_exp(1, t + 1);
    tick();
    push_exp(1, t + 2);
    tick();
    spike_in = '0;
    drain(10);
    check("samebit_drop", drop_count, 0);

    // Drop counting and saturation with a full FIFO
    do_reset();
    aer_ready = 1'b0;
    pulse(16'h00FF);
    repeat (10) tick();
    check("drop_fifo_full", fifo_count, 8);
    pulse(16'h0008);
    check("drop_first_pulse", drop_count, 0);
    pulse(16'h0008);
    check("drop_second_pulse", drop_count, 1);
    for (int n = 1; n <= 20; n++) begin
      pulse(16'hFFFF);
      check("drop_sat", drop_count, sat_drop(16 * n - 14));
    end
    rst_n = 1'b0;
    #1;
    check("droprst_count", fifo_count, 0);
    check("droprst_drop", drop_count, 0);
    check("droprst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    aer_ready = 1'b1;
    repeat (20) tick();
    check("droprst_idle", busy, 0);

    // Timestamp wrap across consecutive events
    do_reset();
    aer_ready = 1'b1;
    for (int i = 0; i < 300 && ts_model != 8'd254; i++) tick();
    check("wrap_align", ts_model, 254);
    t = ts_model;
    spike_in = 16'h0003;
    push_exp(0, t + 1);
    push_exp(1, t + 2);
    tick();
    spike_in = '0;
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aer_spike_encoder.md
Name: aer_spike_encoder

Overview:
- Collects the per-cycle `spike_out` pulses from an array of LIF neurons and serialises them into Address-Event Representation (AER) words.
- Each word carries a neuron address and a timestamp, delivered on a valid/ready stream.
- Sits directly downstream of the neuron array and feeds the AER bus / router.
- Buffers bursts in a small FIFO and counts spikes that are lost to back-pressure.

Parameters:
- NUM_NEURONS, 16, number of neuron spike inputs (2..256).
- ADDR_WIDTH, 4, width of the neuron address; must satisfy 2^ADDR_WIDTH >= NUM_NEURONS.
- TS_WIDTH, 8, width of the free-running timestamp counter.
- FIFO_DEPTH, 8, number of event entries (power of two, >= 2).
- DROP_WIDTH, 8, width of the saturating dropped-spike counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- spike_in  input  NUM_NEURONS  one-cycle spike pulses; bit i is neuron i.
- aer_ready  input  1  downstream accepts the current word.
- aer_valid  output  1  aer_addr/aer_ts hold a valid event.
- aer_addr  output  ADDR_WIDTH  address of the event neuron.
- aer_ts  output  TS_WIDTH  timestamp at which the event was encoded into the FIFO.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of entries in the FIFO.
- drop_count  output  DROP_WIDTH  saturating count of lost spikes.
- busy  output  1  high when the pending register is nonzero or fifo_count != 0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - pending register = 0; FIFO empty; timestamp counter = 0; drop_count = 0.
  - aer_valid = 0; aer_addr = 0; aer_ts = 0; fifo_count = 0; busy = 0.
  - Reset mid-operation discards all pending and buffered events without emitting them.
- Timestamp counter:
  - Increments by 1 every clock and wraps from 2^TS_WIDTH-1 to 0.
- Pending register (NUM_NEURONS bits), updated each edge:
  - pending_next = (pending & ~clear) | spike_in.
  - clear is the one-hot bit of the neuron encoded this cycle, or 0 if none.
- Encoder:
  - Each cycle, if pending != 0 and the FIFO can accept a push, the lowest-index set bit of pending (the registered value, not spike_in) is selected.
  - Its address and the current timestamp counter value are pushed; that bit is cleared.
  - The FIFO can accept a push if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - At most one push per cycle.
- Same-bit events:
  - If spike_in[i] arrives in the cycle bit i is cleared, bit i stays set; this is a new event, not a drop.
  - If spike_in[i] arrives while pending[i] = 1 and is not being cleared, the spike is lost and drop_count increments.
  - Several bits lost in one cycle add their popcount.
  - drop_count saturates at 2^DROP_WIDTH-1; it never wraps.
- FIFO:
  - Show-ahead: aer_valid = (fifo_count != 0); aer_addr/aer_ts are driven from the head entry.
  - Pop occurs when aer_valid && aer_ready.
  - Simultaneous push and pop leave fifo_count unchanged.
  - Pop on empty is impossible, since aer_valid is 0.
  - While aer_valid = 1 and aer_ready = 0, aer_addr/aer_ts hold stable.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Latency:
  - spike_in[i] high before edge E0 sets pending[i] at E0.
  - If i is the lowest pending bit and the FIFO is not full, the push happens at E1 and aer_valid is high after E1.
  - Minimum latency is 2 edges from the sampled spike to a visible event.
- Throughput and ordering:
  - One event per cycle sustained when aer_ready is held high.
  - Among simultaneous spikes, ascending address order is guaranteed.
  - Across cycles, events may reorder only by this priority.
- FIFO full with no pop: no push occurs; spikes accumulate in pending, and drop rules apply.

Test Plan:
- Reset mid-burst: aer_ready = 1; drive spike_in=0x0004 for 1 cycle -> aer_valid rises 2 edges later with aer_addr=2 and aer_ts = timestamp at the push edge (E1); assert rst_n low mid-burst -> all outputs 0 immediately; after release, no stale events appear.
- Simultaneous spikes: aer_ready = 1; spike_in=0x8421 in one cycle -> events come out in address order 0, 5, 10, 15 on consecutive cycles; busy drops after the last pop.
- Back-pressure / full FIFO: aer_ready = 0; pulse all 16 neurons once -> fifo_count reaches 8, pending keeps bits 8..15, drop_count = 0; release ready -> all 16 addresses 0..15 are delivered in order.
- Drop counting: aer_ready = 0 with the FIFO full; pulse neuron 3 twice while pending[3] = 1 -> drop_count = 1; pulse 0xFFFF repeatedly -> drop_count saturates at 255 and stays there.
- Same-bit set/clear: aer_ready = 1; pending = {bit 1 only}; spike_in[1]=1 in the cycle bit 1 is encoded -> two address-1 events are emitted and drop_count is unchanged.
- Timestamp wrap: spike at counter=255 -> aer_ts=255 on that event; the next event one cycle later has aer_ts=0.
